// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light controller timing-parameter path.
// Holds the programmer FSM encoding, bus widths and slot indices.
package tlc_pkg;

  localparam int TP_SEL_W = 2;
  localparam int T_VAL_W  = 4;

  localparam logic [TP_SEL_W-1:0] TP_BASE = 2'd0;
  localparam logic [TP_SEL_W-1:0] TP_EXT  = 2'd1;
  localparam logic [TP_SEL_W-1:0] TP_YEL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_FINISH
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tparam_programmer_phase_timer.sv
// Shared down-counter for the SETUP/PULSE/HOLD phases: load with (cycles-1),
// expire reads high on the last cycle of the phase.
module phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/tparam_programmer.sv
// Stages timing-parameter writes in a shadow bank and, on commit, replays every
// pending slot to the controller in ascending order with setup/pulse/hold framing.
module tparam_programmer
  import tlc_pkg::*;
#(
  parameter int NUM_PARAMS = 3,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 3,
  parameter int HOLD_CYC   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [TP_SEL_W-1:0] wr_sel,
  input  logic [T_VAL_W-1:0]  wr_val,
  output logic                wr_ready,
  input  logic                commit,
  output logic [TP_SEL_W-1:0] tp_sel,
  output logic [T_VAL_W-1:0]  t_val,
  output logic                reprogram,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t state, next_state;

  logic [NUM_PARAMS-1:0] pending, pend_mix, pend_next;
  logic [T_VAL_W-1:0]    shadow  [NUM_PARAMS];
  logic [T_VAL_W-1:0]    val_mix [NUM_PARAMS];

  logic                wr_fire, wr_ok;
  logic                found, take;
  logic [TP_SEL_W-1:0] low_sel;
  logic [T_VAL_W-1:0]  low_val;
  logic                tmr_load, expire;
  logic [CNT_W-1:0]    tmr_val;

  // Fold a same-cycle write into the bank view so a write+commit is applied.
  // NOTE: every always_comb output gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    wr_fire  = wr_valid && (state == ST_IDLE);
    wr_ok    = wr_fire && (int'(wr_sel) < NUM_PARAMS);
    pend_mix = pending;
    val_mix  = shadow;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (wr_ok && (wr_sel == TP_SEL_W'(i))) begin
        pend_mix[i] = 1'b1;
        val_mix[i]  = wr_val;
      end
    end
    found   = 1'b0;
    low_sel = '0;
    low_val = '0;
    for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
      if (pend_mix[i]) begin
        found   = 1'b1;
        low_sel = TP_SEL_W'(i);
        low_val = val_mix[i];
      end
    end
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) begin
          take       = found;
          next_state = found ? ST_SETUP : ST_FINISH;
        end
      end
      ST_SETUP:  if (expire) next_state = ST_PULSE;
      ST_PULSE:  if (expire) next_state = ST_HOLD;
      ST_HOLD: begin
        if (expire) begin
          take       = found;
          next_state = found ? ST_SETUP : ST_FINISH;
        end
      end
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_next = pend_mix;
    if (take) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (low_sel == TP_SEL_W'(i)) pend_next[i] = 1'b0;
      end
    end
  end

  // Every phase entry (including HOLD -> SETUP of the next slot) reloads the timer.
  always_comb begin
    tmr_load = (next_state != state);
    case (next_state)
      ST_SETUP: tmr_val = CNT_W'(SETUP_CYC - 1);
      ST_PULSE: tmr_val = CNT_W'(PULSE_CYC - 1);
      ST_HOLD:  tmr_val = CNT_W'(HOLD_CYC - 1);
      default:  tmr_val = '0;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: the shadow bank is reset explicitly because cleared values are
  // architecturally visible; it is a handful of flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
      tp_sel  <= '0;
      t_val   <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pend_next;
      shadow  <= val_mix;
      err     <= wr_fire && !wr_ok;
      if (take) begin
        tp_sel <= low_sel;
        t_val  <= low_val;
      end
    end
  end

  // Decoded from state so the async reset drops reprogram without a clock edge.
  assign wr_ready  = (state == ST_IDLE);
  assign reprogram = (state == ST_PULSE);
  assign busy      = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);
  assign done      = (state == ST_FINISH);

endmodule
